// File: rtl/wb_regfile_writeback.sv
// wb_regfile_writeback: write-back stage and 8 x 16-bit architectural register file.
// Selects the write-back value from the MEM/WB register and commits it to the file.
// It also serves two decode read ports and holds a one-entry history of the last
// commit for EX forwarding. A wrapping retire counter and a sticky protocol-error
// flag are kept alongside.
//
// Configuration macro: WB_BYPASS_EN. When it is defined, a read of the register being
// committed this cycle returns wb_data in the same cycle (write-through).
//
// Ports:
//   clock, reset                  clock; synchronous active-high reset
//   wb_fwd_reg  [2:0]             destination register index
//   wb_lb_const [7:0]             load-byte constant
//   wb_mem_out, wb_alu_out [15:0] memory / ALU results
//   wb_memtoreg [1:0]             source select (00 alu, 01 mem, 10 lo byte, 11 hi byte)
//   wb_regwrite, wb_mem_read      write request / instruction read memory
//   rd_addr_a/b, rd_data_a/b      decode read ports (data combinational)
//   wb_data, wb_commit            selected value / commit strobe (combinational)
//   hist_valid/reg/data           last committed write (registered)
//   retire_cnt [15:0]             committed-write count, wraps
//   proto_err                     sticky: mem-sourced write without a memory read
module wb_regfile_writeback #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [2:0]    wb_fwd_reg,
    input  logic [7:0]    wb_lb_const,
    input  logic [DW-1:0] wb_mem_out,
    input  logic [DW-1:0] wb_alu_out,
    input  logic [1:0]    wb_memtoreg,
    input  logic          wb_regwrite,
    input  logic          wb_mem_read,
    input  logic [2:0]    rd_addr_a,
    input  logic [2:0]    rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    output logic [DW-1:0] wb_data,
    output logic          wb_commit,
    output logic          hist_valid,
    output logic [2:0]    hist_reg,
    output logic [DW-1:0] hist_data,
    output logic [15:0]   retire_cnt,
    output logic          proto_err
);

    localparam int unsigned CW = 16;

    logic [DW-1:0] r_regs [NREGS];
    logic          r_hist_valid;
    logic [2:0]    r_hist_reg;
    logic [DW-1:0] r_hist_data;
    logic [CW-1:0] r_retire_cnt;
    logic          r_proto_err;

    logic [7:0]    w_cur_lo;
    logic          w_err;

    // Low byte of the destination before this edge, for the load-high merge
    assign w_cur_lo = r_regs[wb_fwd_reg][7:0];

    // A memory-sourced write from an instruction that never read memory is illegal
    assign w_err     = wb_regwrite & (wb_memtoreg == 2'b01) & ~wb_mem_read;
    assign wb_commit = wb_regwrite & (wb_fwd_reg != 3'd0) & ~w_err;

    // Write-back source select
    always_comb begin
        wb_data = wb_alu_out;
        case (wb_memtoreg)
            2'b00:   wb_data = wb_alu_out;
            2'b01:   wb_data = wb_mem_out;
            2'b10:   wb_data = DW'(wb_lb_const);
            default: wb_data = DW'({wb_lb_const, w_cur_lo});
        endcase
    end

    // Decode read ports; R0 is hard-wired to zero
    always_comb begin
        rd_data_a = r_regs[rd_addr_a];
        rd_data_b = r_regs[rd_addr_b];
`ifdef WB_BYPASS_EN
        if (wb_commit && (rd_addr_a == wb_fwd_reg)) rd_data_a = wb_data;
        if (wb_commit && (rd_addr_b == wb_fwd_reg)) rd_data_b = wb_data;
`endif
        if (rd_addr_a == 3'd0) rd_data_a = '0;
        if (rd_addr_b == 3'd0) rd_data_b = '0;
    end

    // Register file, history, retire counter and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_hist_valid <= 1'b0;
            r_hist_reg   <= 3'd0;
            r_hist_data  <= '0;
            r_retire_cnt <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (wb_commit) begin
                r_regs[wb_fwd_reg] <= wb_data;
                r_hist_reg         <= wb_fwd_reg;
                r_hist_data        <= wb_data;
                r_retire_cnt       <= r_retire_cnt + CW'(1);
            end
            r_hist_valid <= wb_commit;
            if (w_err) r_proto_err <= 1'b1;
        end
    end

    assign hist_valid = r_hist_valid;
    assign hist_reg   = r_hist_reg;
    assign hist_data  = r_hist_data;
    assign retire_cnt = r_retire_cnt;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_wb_regfile_writeback.sv
// Testbench for wb_regfile_writeback: directed test-plan sequences plus randomized
// traffic, checked every cycle against a behavioural register-file model.
module tb_wb_regfile_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  wb_fwd_reg;
    logic [7:0]  wb_lb_const;
    logic [15:0] wb_mem_out, wb_alu_out;
    logic [1:0]  wb_memtoreg;
    logic        wb_regwrite, wb_mem_read;
    logic [2:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b, wb_data;
    logic        wb_commit, hist_valid, proto_err;
    logic [2:0]  hist_reg;
    logic [15:0] hist_data, retire_cnt;

    wb_regfile_writeback dut (
        .clock(clock), .reset(reset),
        .wb_fwd_reg(wb_fwd_reg), .wb_lb_const(wb_lb_const),
        .wb_mem_out(wb_mem_out), .wb_alu_out(wb_alu_out),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_mem_read(wb_mem_read),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wb_data(wb_data), .wb_commit(wb_commit),
        .hist_valid(hist_valid), .hist_reg(hist_reg), .hist_data(hist_data),
        .retire_cnt(retire_cnt), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    int tests  = 0;
    int failed = 0;

    // Behavioural model state
    logic [15:0] m_r [8];
    logic        m_hv;
    logic [2:0]  m_hr;
    logic [15:0] m_hd;
    int          m_cnt;
    logic        m_err;
    bit          checking = 0;
    logic [15:0] got;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a, input logic cm,
                                           input logic [2:0] fr, input logic [15:0] d);
        if (a == 3'd0) return 16'h0000;
`ifdef WB_BYPASS_EN
        if (cm && a == fr) return d;
`endif
        return m_r[a];
    endfunction

    // One clock cycle: drive, compare everything against the model, clock, update model
    task automatic cyc(input logic rst, input logic regw, input logic mrd,
                       input logic [2:0] fr, input logic [1:0] sel, input logic [7:0] c,
                       input logic [15:0] mem, input logic [15:0] alu,
                       input logic [2:0] ra, input logic [2:0] rb, output logic [15:0] got_a);
        logic [15:0] ed;
        logic        ec, ee;
        reset = rst; wb_regwrite = regw; wb_mem_read = mrd; wb_fwd_reg = fr;
        wb_memtoreg = sel; wb_lb_const = c; wb_mem_out = mem; wb_alu_out = alu;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
        case (sel)
            2'd0: ed = alu;
            2'd1: ed = mem;
            2'd2: ed = {8'h00, c};
            default: ed = {c, m_r[fr][7:0]};
        endcase
        ee = regw && sel == 2'd1 && !mrd;
        ec = regw && fr != 3'd0 && !ee;
        if (checking) begin
            chk("wb_data",    wb_data, ed);
            chk("wb_commit",  16'(wb_commit), 16'(ec));
            chk("rd_data_a",  rd_data_a, m_read(ra, ec, fr, ed));
            chk("rd_data_b",  rd_data_b, m_read(rb, ec, fr, ed));
            chk("hist_valid", 16'(hist_valid), 16'(m_hv));
            chk("hist_reg",   16'(hist_reg), 16'(m_hr));
            chk("hist_data",  hist_data, m_hd);
            chk("retire_cnt", retire_cnt, 16'(m_cnt));
            chk("proto_err",  16'(proto_err), 16'(m_err));
        end
        got_a = rd_data_a;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
            m_hv = 0; m_hr = 0; m_hd = 0; m_cnt = 0; m_err = 0;
            checking = 1;
        end else begin
            if (ec) begin
                m_r[fr] = ed; m_hr = fr; m_hd = ed;
                m_cnt = (m_cnt + 1) % 65536;
            end
            m_hv = ec;
            if (ee) m_err = 1;
        end
        @(negedge clock);
    endtask

    task automatic idle(input logic [2:0] ra);
        cyc(0, 0, 0, 3'd0, 2'd0, 8'h00, 16'h0, 16'h0, ra, 3'd0, got);
    endtask

    // Set read addresses on an idle input set and return port A without clocking
    task automatic peek(input logic [2:0] ra, output logic [15:0] v);
        reset = 0; wb_regwrite = 0; wb_mem_read = 0; wb_fwd_reg = 0; wb_memtoreg = 0;
        rd_addr_a = ra; rd_addr_b = 3'd0;
        #1;
        v = rd_data_a;
    endtask

    initial begin
        logic [15:0] v;
        // Reset, write R3, reset again
        cyc(1, 0, 0, 3'd0, 2'd0, 8'h00, 16'h0, 16'h0, 3'd0, 3'd0, got);
        cyc(0, 1, 0, 3'd3, 2'd0, 8'h00, 16'h0, 16'h1234, 3'd3, 3'd0, got);
        peek(3'd3, v); chk("pre_reset_r3", v, 16'h1234);
        cyc(1, 0, 0, 3'd0, 2'd0, 8'h00, 16'h0, 16'h0, 3'd3, 3'd0, got);
        peek(3'd3, v); chk("reset_r3", v, 16'h0000);
        chk("reset_cnt", retire_cnt, 16'h0000);
        chk("reset_hv", 16'(hist_valid), 16'h0);
        chk("reset_err", 16'(proto_err), 16'h0);

        // ALU write
        cyc(0, 1, 0, 3'd5, 2'd0, 8'h00, 16'h0, 16'hBEEF, 3'd0, 3'd0, got);
        peek(3'd5, v); chk("alu_r5", v, 16'hBEEF);
        chk("alu_hreg", 16'(hist_reg), 16'd5);
        chk("alu_hdata", hist_data, 16'hBEEF);
        chk("alu_hv", 16'(hist_valid), 16'h1);
        chk("alu_cnt", retire_cnt, 16'd1);
        idle(3'd5);
        chk("alu_hv_drop", 16'(hist_valid), 16'h0);

        // Byte loads
        cyc(0, 1, 1, 3'd2, 2'd2, 8'h34, 16'h0, 16'h0, 3'd0, 3'd0, got);
        peek(3'd2, v); chk("lb_lo", v, 16'h0034);
        cyc(0, 1, 1, 3'd2, 2'd3, 8'h12, 16'h0, 16'h0, 3'd0, 3'd0, got);
        peek(3'd2, v); chk("lb_hi", v, 16'h1234);
        chk("lb_cnt", retire_cnt, 16'd3);

        // R0 write is dropped
        cyc(0, 1, 0, 3'd0, 2'd0, 8'h00, 16'h0, 16'hFFFF, 3'd0, 3'd0, got);
        peek(3'd0, v); chk("r0_read", v, 16'h0000);
        chk("r0_cnt", retire_cnt, 16'd3);

        // Protocol error: mem-sourced write without mem read
        cyc(0, 1, 0, 3'd4, 2'd1, 8'h00, 16'h5555, 16'h0, 3'd0, 3'd0, got);
        peek(3'd4, v); chk("perr_r4", v, 16'h0000);
        chk("perr_set", 16'(proto_err), 16'h1);
        for (int i = 0; i < 10; i++) idle(3'd4);
        chk("perr_held", 16'(proto_err), 16'h1);

        // Same-cycle read of the register being committed
        cyc(0, 1, 0, 3'd6, 2'd0, 8'h00, 16'h0, 16'hA5A5, 3'd6, 3'd6, got);
`ifdef WB_BYPASS_EN
        chk("bypass_same", got, 16'hA5A5);
`else
        chk("bypass_same", got, 16'h0000);
`endif
        peek(3'd6, v); chk("bypass_next", v, 16'hA5A5);

        // Simultaneous reset and commit
        cyc(1, 1, 1, 3'd1, 2'd0, 8'h00, 16'h0, 16'h7777, 3'd1, 3'd0, got);
        peek(3'd1, v); chk("rst_commit_r1", v, 16'h0000);
        chk("rst_commit_cnt", retire_cnt, 16'h0000);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) != 0), 3'($urandom), 2'($urandom), 8'($urandom),
                16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom), got);
        end

        // Counter wrap
        cyc(1, 0, 0, 3'd0, 2'd0, 8'h00, 16'h0, 16'h0, 3'd0, 3'd0, got);
        for (int i = 0; i < 65535; i++)
            cyc(0, 1, 1, 3'($urandom_range(1, 7)), 2'd0, 8'h00, 16'h0, 16'($urandom),
                3'($urandom), 3'($urandom), got);
        chk("cnt_ffff", retire_cnt, 16'hFFFF);
        cyc(0, 1, 1, 3'd7, 2'd0, 8'h00, 16'h0, 16'h1111, 3'd7, 3'd0, got);
        chk("cnt_wrap", retire_cnt, 16'h0000);
        peek(3'd7, v); chk("wrap_r7", v, 16'h1111);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
